// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b with start/busy/done handshake
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, res_q, res_d, diff_q, diff_d, res_sh;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic brw_q, brw_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic bo_q, bo_d, ov_q, ov_d, z_q, z_d;
  logic d_bit, brw_nx, last;
  assign busy       = state_q == SHIFT;
  assign done       = state_q == DONE;
  assign diff       = diff_q;
  assign borrow_out = bo_q;
  assign overflow   = ov_q;
  assign zero       = z_q;
  // next state: one full-subtractor step per SHIFT cycle, flags published on the last bit
  always_comb begin
    d_bit   = ra_q[0] ^ rb_q[0] ^ brw_q;
    brw_nx  = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & brw_q);
    res_sh  = {d_bit, res_q[WIDTH-1:1]};
    last    = cnt_q == LAST;
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    z_d     = z_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        ra_d    = a;
        rb_d    = b;
        res_d   = '0;
        brw_d   = 1'b0;
        cnt_d   = '0;
        amsb_d  = a[WIDTH-1];
        bmsb_d  = b[WIDTH-1];
      end
      SHIFT: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        res_d = res_sh;
        brw_d = brw_nx;
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          diff_d  = res_sh;
          bo_d    = brw_nx;
          ov_d    = (amsb_q != bmsb_q) && (res_sh[WIDTH-1] != amsb_q);
          z_d     = res_sh == '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously so an in-flight op is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
      z_q     <= z_d;
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed WIDTH=8 vectors plus WIDTH=32 random regression
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s8 = 1'b0, s32 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic busy8, done8, bo8, ov8, z8;
  logic busy32, done32, bo32, ov32, z32;
  logic [7:0] diff8;
  logic [31:0] diff32;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8),
    .borrow_out(bo8), .overflow(ov8), .zero(z8)
  );
  serial_subtractor #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(s32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .diff(diff32),
    .borrow_out(bo32), .overflow(ov32), .zero(z32)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_done8(output int lat, output int nb);
    lat = 0;
    nb = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy8) nb++;
    end
  endtask
  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                     input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
    int lat, nb;
    @(negedge clk);
    a8 = ta;
    b8 = tb_;
    s8 = 1'b1;
    @(posedge clk);
    #1 s8 = 1'b0;
    a8 = ~ta;
    b8 = ~tb_;
    wait_done8(lat, nb);
    chk({tag, " lat"}, 64'(lat), 64'd9);
    chk({tag, " busy"}, 64'(nb), 64'd8);
    chk({tag, " diff"}, 64'(diff8), 64'(ed));
    chk({tag, " bo"}, 64'(bo8), 64'(eb));
    chk({tag, " ov"}, 64'(ov8), 64'(eo));
    chk({tag, " z"}, 64'(z8), 64'(ez));
  endtask
  task automatic op32(input logic [31:0] ta, input logic [31:0] tb_);
    int lat;
    longint sd;
    logic [32:0] ud;
    logic eov;
    ud = {1'b0, ta} - {1'b0, tb_};
    sd = longint'($signed(ta)) - longint'($signed(tb_));
    eov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    @(negedge clk);
    a32 = ta;
    b32 = tb_;
    s32 = 1'b1;
    @(posedge clk);
    #1 s32 = 1'b0;
    a32 = $urandom;
    b32 = $urandom;
    lat = 0;
    while (!done32 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("w32 lat", 64'(lat), 64'd33);
    chk("w32 diff", 64'(diff32), 64'(ud[31:0]));
    chk("w32 bo", 64'(bo32), 64'(ud[32]));
    chk("w32 ov", 64'(ov32), 64'(eov));
    chk("w32 z", 64'(z32), 64'(ud[31:0] == 32'd0));
  endtask
  initial begin
    int lat, nb, pulses, last_t;
    logic [31:0] ra, rb;
    #2;
    chk("rst busy", 64'(busy8), 64'd0);
    chk("rst done", 64'(done8), 64'd0);
    chk("rst diff", 64'(diff8), 64'd0);
    chk("rst flags", 64'({bo8, ov8, z8}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    op8("basic", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold diff", 64'(diff8), 64'h02);
    chk("hold done", 64'(done8), 64'd0);
    op8("borrow", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
    op8("min-1", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    op8("7f-ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    op8("x-x", 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1);
    op8("0-0", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    op8("0-1", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
    op8("64-9c", 8'h64, 8'h9C, 8'hC8, 1'b1, 1'b1, 1'b0);
    // start re-asserted mid-SHIFT must be ignored
    @(negedge clk);
    a8 = 8'h05;
    b8 = 8'h03;
    s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'h33;
    b8 = 8'h11;
    s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    wait_done8(lat, nb);
    chk("midstart diff", 64'(diff8), 64'h02);
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    chk("midstart extra done", 64'(pulses), 64'd0);
    chk("midstart hold", 64'(diff8), 64'h02);
    // start held high: one op every 10 cycles
    a8 = 8'h09;
    b8 = 8'h04;
    s8 = 1'b1;
    pulses = 0;
    last_t = -1;
    for (int t = 0; t < 45; t++) begin
      @(negedge clk);
      if (done8) begin
        if (last_t >= 0) chk("held period", 64'(t - last_t), 64'd10);
        last_t = t;
        pulses++;
      end
    end
    chk("held pulses", 64'(pulses), 64'd4);
    chk("held diff", 64'(diff8), 64'h05);
    s8 = 1'b0;
    repeat (12) @(negedge clk);
    // asynchronous reset four cycles into SHIFT
    a8 = 8'h40;
    b8 = 8'h01;
    s8 = 1'b1;
    @(posedge clk);
    #1 s8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst busy", 64'(busy8), 64'd0);
    chk("arst done", 64'(done8), 64'd0);
    chk("arst diff", 64'(diff8), 64'd0);
    chk("arst flags", 64'({bo8, ov8, z8}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    op8("post-rst", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);
    op32(32'h8000_0000, 32'h0000_0001);
    op32(32'h0000_0000, 32'h0000_0001);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = (i % 50 == 0) ? ra : $urandom;
      op32(ra, rb);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
